pe_single_conv_ctrl: RTL and testbench
======================================

Name: pe_single_conv_ctrl

Overview:
Sequencer for the single-PE convolution datapath. It computes a 3x3-filter convolution over a 4x4 input matrix, which gives a 2x2 output, by time-multiplexing one PE. For each output window it drives the PE input-mux selects (s0 picks the a element, s1 picks the b element) and the PE init strobe. It captures the PE result into a 2x2 result register file and signals completion.

Parameters:
PE_LAT, 1, cycles from the clock edge of the last MAC of a window until pe_out holds that window's sum (legal range 1..3).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to run a full 2x2 convolution; sampled only in IDLE.
pe_out  input  8  accumulated result from the PE computation module.
s0  output  4  a-matrix select, row-major (a11=0 .. a44=15).
s1  output  4  b-matrix select, row-major (b11=0 .. b33=8).
init  output  1  PE accumulator init: this cycle's product replaces the accumulator instead of adding to it.
busy  output  1  high from the first RUN cycle through the last CAPTURE cycle.
done  output  1  one-cycle pulse when all four results are latched.
res_valid  output  1  results valid; set with done, cleared on an accepted start or on rst.
c11, c12, c21, c22  output  8 each  convolution results, windows w0..w3.

Behaviour:
- States: IDLE, RUN, CAPTURE, DONE. Counters:
  - tap k, 0..8;
  - window w, 0..3;
  - wait counter, 0..PE_LAT-1.
- rst (any state, any cycle): next state IDLE, k=w=0.
  - s0=s1=0, init=0, busy=0, done=0, res_valid=0, c11..c22=0.
  - A reset in mid-operation abandons the run; no partial results are kept.
- IDLE: s0=s1=0, init=0, busy=0.
  - start=1 -> RUN with k=0, w=0; res_valid cleared on the same edge.
  - c11..c22 hold their previous values.
- RUN: busy=1.
  - s1 = k.
  - s0 = base(w) + 4*(k/3) + (k%3), with base = 0, 1, 4, 5 for w0..w3.
  - init = 1 only when k==0.
  - k increments each cycle. At k==8: k -> 0, go to CAPTURE.
- CAPTURE: s0=s1=0, init=0, busy=1. Stays PE_LAT cycles.
  - On its final cycle, pe_out is latched into c[w]: w0->c11, w1->c12, w2->c21, w3->c22.
  - Then: if w<3, w increments and the state returns to RUN; if w==3, go to DONE.
- DONE: one cycle. done=1, res_valid set, busy=0, then IDLE.
- start is ignored in RUN, CAPTURE and DONE. It is not queued.
- Timing, with the start edge as cycle 0 and PE_LAT=1:
  - window w occupies cycles 10w+1 .. 10w+10;
  - c22 is latched at the end of cycle 40;
  - done=1 in cycle 41;
  - total 4*(9+PE_LAT)+1 cycles.
- Arithmetic: the controller does no arithmetic on data. It captures 8-bit pe_out verbatim; any wrap or overflow is the PE's.
- Outputs are registered or decoded from state only. There is no combinational path from pe_out or start to any output.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; busy=0; done never asserted.
- a=all 1, b=all 1, pulse start -> busy cycles 1..40; done only in cycle 41; c11=c12=c21=c22=9; res_valid=1.
- a11..a44 = 1..16, b22=1 and all other b=0 -> c11=6, c12=7, c21=10, c22=11. Also check the s0 trace for w1 is 1,2,3,5,6,7,9,10,11, with init high only on its first cycle.
- Pulse start again in cycles 5 and 41 -> both ignored; exactly one done; results unchanged.
- Assert rst in cycle 15 -> next cycle IDLE with busy=0, s0=0, res_valid=0 and c11 cleared. A new start then completes normally with correct results.
- PE_LAT=2 instance with the all-ones data -> done in cycle 45; all results 9.

Source files
------------

// File: rtl/pe_single_conv_ctrl_if.sv
// Purpose: bundles the convolution sequencer's control, PE-select and result signals.
// Latency: none; wires only.
// Backpressure: none; start is a single-cycle request and is dropped when the sequencer is busy.
interface pe_single_conv_ctrl_if;
    logic       start;
    logic [7:0] pe_out;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       init;
    logic       busy;
    logic       done;
    logic       res_valid;
    logic [7:0] c11;
    logic [7:0] c12;
    logic [7:0] c21;
    logic [7:0] c22;

    // Sequencer side: takes start and the PE result, drives selects and results.
    modport master (
        input  start, pe_out,
        output s0, s1, init, busy, done, res_valid, c11, c12, c21, c22
    );

    // Requester / PE side.
    modport slave (
        output start, pe_out,
        input  s0, s1, init, busy, done, res_valid, c11, c12, c21, c22
    );
endinterface

// File: rtl/pe_single_conv_ctrl.sv
// Purpose: time-multiplexes one PE over four 3x3 windows of a 4x4 matrix, capturing a 2x2 result.
// Latency: 4*(9+PE_LAT)+1 cycles from the start edge to the done pulse.
// Backpressure: none; start is sampled only in IDLE and is neither queued nor acknowledged.
module pe_single_conv_ctrl #(
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    pe_single_conv_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(PE_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_k;
    logic [1:0] r_w;
    logic [1:0] r_wait;
    logic       r_res_valid;
    logic [7:0] r_c11, r_c12, r_c21, r_c22;

    logic       w_k_last;
    logic       w_wait_last;
    logic [3:0] w_s0;
    logic [3:0] w_s1;
    logic       w_init;
    logic       w_busy;
    logic       w_done;

    // Top-left a-element of each window: a11, a12, a21, a22.
    function automatic logic [3:0] win_base(input logic [1:0] w);
        case (w)
            2'd0:    win_base = 4'd0;
            2'd1:    win_base = 4'd1;
            2'd2:    win_base = 4'd4;
            default: win_base = 4'd5;
        endcase
    endfunction

    // Row-major offset of tap k inside a 3x3 window laid over a 4-wide matrix.
    function automatic logic [3:0] tap_off(input logic [3:0] k);
        case (k)
            4'd0:    tap_off = 4'd0;
            4'd1:    tap_off = 4'd1;
            4'd2:    tap_off = 4'd2;
            4'd3:    tap_off = 4'd4;
            4'd4:    tap_off = 4'd5;
            4'd5:    tap_off = 4'd6;
            4'd6:    tap_off = 4'd8;
            4'd7:    tap_off = 4'd9;
            4'd8:    tap_off = 4'd10;
            default: tap_off = 4'd0;
        endcase
    endfunction

    assign w_k_last    = (r_k == 4'd8);
    assign w_wait_last = (r_wait == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and state-decoded PE controls.
    always_comb begin
        w_next = r_state;
        w_s0   = 4'd0;
        w_s1   = 4'd0;
        w_init = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_s1   = r_k;
                w_s0   = win_base(r_w) + tap_off(r_k);
                w_init = (r_k == 4'd0);
                if (w_k_last) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_busy = 1'b1;
                if (w_wait_last) w_next = (r_w == 2'd3) ? S_DONE : S_RUN;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Tap/window/wait counters, result capture and the sticky results-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= 4'd0;
            r_w         <= 2'd0;
            r_wait      <= 2'd0;
            r_res_valid <= 1'b0;
            r_c11       <= 8'd0;
            r_c12       <= 8'd0;
            r_c21       <= 8'd0;
            r_c22       <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_k    <= 4'd0;
                    r_w    <= 2'd0;
                    r_wait <= 2'd0;
                    if (bus.start) r_res_valid <= 1'b0;
                end
                S_RUN: begin
                    r_wait <= 2'd0;
                    r_k    <= w_k_last ? 4'd0 : r_k + 4'd1;
                end
                S_CAPTURE: begin
                    if (w_wait_last) begin
                        r_wait <= 2'd0;
                        case (r_w)
                            2'd0:    r_c11 <= bus.pe_out;
                            2'd1:    r_c12 <= bus.pe_out;
                            2'd2:    r_c21 <= bus.pe_out;
                            default: r_c22 <= bus.pe_out;
                        endcase
                        // res_valid rises together with c22 so it is high during the done cycle.
                        if (r_w == 2'd3) r_res_valid <= 1'b1;
                        else             r_w         <= r_w + 2'd1;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                default: begin
                    r_k <= 4'd0;
                    r_w <= 2'd0;
                end
            endcase
        end
    end

    assign bus.s0        = w_s0;
    assign bus.s1        = w_s1;
    assign bus.init      = w_init;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.res_valid = r_res_valid;
    assign bus.c11       = r_c11;
    assign bus.c12       = r_c12;
    assign bus.c21       = r_c21;
    assign bus.c22       = r_c22;
endmodule

// File: tb/tb_pe_single_conv_ctrl.sv
// Purpose: checks the convolution sequencer at PE_LAT=1 and PE_LAT=2 against a cycle-indexed model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_pe_single_conv_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [7:0] a[16];
    logic [7:0] b[9];

    pe_single_conv_ctrl_if u_if0 ();
    pe_single_conv_ctrl_if u_if1 ();

    // Behavioural PE: MAC every cycle, result visible PE_LAT cycles after the MAC edge.
    logic [7:0] acc[2];
    logic [7:0] dly1;

    assign u_if0.start  = start;
    assign u_if1.start  = start;
    assign u_if0.pe_out = acc[0];
    assign u_if1.pe_out = dly1;

    pe_single_conv_ctrl #(.PE_LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0.master));
    pe_single_conv_ctrl #(.PE_LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.master));

    logic [3:0] d_s0[2], d_s1[2];
    logic       d_init[2], d_busy[2], d_done[2], d_rv[2];
    logic [7:0] d_c[2][4];

    assign d_s0[0] = u_if0.s0;        assign d_s0[1] = u_if1.s0;
    assign d_s1[0] = u_if0.s1;        assign d_s1[1] = u_if1.s1;
    assign d_init[0] = u_if0.init;    assign d_init[1] = u_if1.init;
    assign d_busy[0] = u_if0.busy;    assign d_busy[1] = u_if1.busy;
    assign d_done[0] = u_if0.done;    assign d_done[1] = u_if1.done;
    assign d_rv[0] = u_if0.res_valid; assign d_rv[1] = u_if1.res_valid;
    assign d_c[0][0] = u_if0.c11;     assign d_c[1][0] = u_if1.c11;
    assign d_c[0][1] = u_if0.c12;     assign d_c[1][1] = u_if1.c12;
    assign d_c[0][2] = u_if0.c21;     assign d_c[1][2] = u_if1.c21;
    assign d_c[0][3] = u_if0.c22;     assign d_c[1][3] = u_if1.c22;

    function automatic logic [7:0] prod_of(input logic [3:0] s0v, input logic [3:0] s1v);
        logic [15:0] p;
        p = a[s0v] * ((s1v < 4'd9) ? b[s1v] : 8'd0);
        return p[7:0];
    endfunction

    always @(posedge clk) begin
        acc[0] <= d_init[0] ? prod_of(d_s0[0], d_s1[0]) : acc[0] + prod_of(d_s0[0], d_s1[0]);
        acc[1] <= d_init[1] ? prod_of(d_s0[1], d_s1[1]) : acc[1] + prod_of(d_s0[1], d_s1[1]);
        dly1   <= acc[1];
    end

    // Direct 3x3 convolution of window w (8-bit wrap, like the PE).
    function automatic logic [7:0] conv(input int w);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(a[((w / 2) + i) * 4 + (w % 2) + j]) * int'(b[i * 3 + j]);
        return 8'(s);
    endfunction

    // Model: n = cycles since the start edge (0 = idle). Each window takes P = 9+PE_LAT cycles.
    int         n[2] = '{0, 0};
    int         P[2] = '{10, 11};
    logic [7:0] exp_c[2][4];
    logic       exp_rv[2];
    int         done_cnt[2] = '{0, 0};
    int         done_cyc[2] = '{0, 0};
    int         busy_cnt[2] = '{0, 0};

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                n[d] = 0;
                exp_rv[d] = 1'b0;
                for (int j = 0; j < 4; j++) exp_c[d][j] = 8'd0;
            end else if (n[d] == 0) begin
                if (start) begin
                    n[d] = 1;
                    exp_rv[d] = 1'b0;
                end
            end else begin
                if ((n[d] % P[d]) == 0 && n[d] <= 4 * P[d]) begin
                    exp_c[d][n[d] / P[d] - 1] = conv(n[d] / P[d] - 1);
                    if (n[d] == 4 * P[d]) exp_rv[d] = 1'b1;
                end
                n[d] = (n[d] == 4 * P[d] + 1) ? 0 : n[d] + 1;
            end
        end
    end

    task automatic check(input string nm, input int d, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0d required=%0d", nm, d, cyc, act, req);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int e_s0, e_s1, e_init, e_busy, e_done, w, t;
                int base[4];
                base = '{0, 1, 4, 5};
                e_s0 = 0; e_s1 = 0; e_init = 0; e_busy = 0; e_done = 0;
                if (n[d] >= 1 && n[d] <= 4 * P[d]) begin
                    w = (n[d] - 1) / P[d];
                    t = (n[d] - 1) % P[d];
                    e_busy = 1;
                    if (t < 9) begin
                        e_s0 = base[w] + 4 * (t / 3) + (t % 3);
                        e_s1 = t;
                        e_init = (t == 0) ? 1 : 0;
                    end
                end else if (n[d] == 4 * P[d] + 1) begin
                    e_done = 1;
                end
                check("s0", d, int'(d_s0[d]), e_s0);
                check("s1", d, int'(d_s1[d]), e_s1);
                check("init", d, int'(d_init[d]), e_init);
                check("busy", d, int'(d_busy[d]), e_busy);
                check("done", d, int'(d_done[d]), e_done);
                check("res_valid", d, int'(d_rv[d]), int'(exp_rv[d]));
                for (int j = 0; j < 4; j++) check("c", d, int'(d_c[d][j]), int'(exp_c[d][j]));
                if (d_done[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                end
                if (d_busy[d]) busy_cnt[d]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 of the run; returns the cycle-0 counter value.
    task automatic pulse_start(output int s_cyc);
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 16; i++) a[i] = (mode == 0) ? 8'd1 : 8'(i + 1);
        for (int i = 0; i < 9; i++)  b[i] = (mode == 0) ? 8'd1 : ((i == 4) ? 8'd1 : 8'd0);
    endtask

    int s_cyc;
    int exp_tr[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int exp_c3[4] = '{6, 7, 10, 11};
    int tr_s0[9];
    int tr_init[9];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fill(0);
        repeat (3) tick();
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (5) tick();
        check("idle_busy", 0, int'(d_busy[0]), 0);
        check("idle_s0", 0, int'(d_s0[0]), 0);
        check("idle_c11", 0, int'(d_c[0][0]), 0);
        check("idle_rv", 0, int'(d_rv[0]), 0);
        check("idle_done_cnt", 0, done_cnt[0], 0);

        // All-ones data: every window sums to 9.
        fill(0);
        done_cnt = '{0, 0};
        busy_cnt = '{0, 0};
        pulse_start(s_cyc);
        repeat (50) tick();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 4; j++) check("ones_c", d, int'(d_c[d][j]), 9);
            check("ones_rv", d, int'(d_rv[d]), 1);
            check("ones_done_cnt", d, done_cnt[d], 1);
            check("ones_busy_cnt", d, busy_cnt[d], (d == 0) ? 40 : 44);
        end
        check("ones_done_cycle", 0, done_cyc[0] - s_cyc, 41);
        check("ones_done_cycle", 1, done_cyc[1] - s_cyc, 45);

        // Ramp a, centre-only b: each result is the window's centre element.
        fill(1);
        pulse_start(s_cyc);
        repeat (10) tick();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tr_s0[i] = int'(d_s0[0]);
            tr_init[i] = int'(d_init[0]);
            tick();
        end
        repeat (40) tick();
        for (int i = 0; i < 9; i++) begin
            check("w1_s0_trace", 0, tr_s0[i], exp_tr[i]);
            check("w1_init_trace", 0, tr_init[i], (i == 0) ? 1 : 0);
        end
        for (int d = 0; d < 2; d++)
            for (int j = 0; j < 4; j++) check("centre_c", d, int'(d_c[d][j]), exp_c3[j]);

        // Extra starts in cycles 5 and 41 must be dropped.
        done_cnt = '{0, 0};
        pulse_start(s_cyc);
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (35) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        for (int d = 0; d < 2; d++) begin
            check("ignore_done_cnt", d, done_cnt[d], 1);
            check("ignore_busy", d, int'(d_busy[d]), 0);
            for (int j = 0; j < 4; j++) check("ignore_c", d, int'(d_c[d][j]), exp_c3[j]);
        end

        // Reset in cycle 15 abandons the run and clears results.
        fill(0);
        pulse_start(s_cyc);
        repeat (14) tick();
        check("pre_rst_c11", 0, int'(d_c[0][0]), 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 0, int'(d_busy[0]), 0);
        check("rst_s0", 0, int'(d_s0[0]), 0);
        check("rst_rv", 0, int'(d_rv[0]), 0);
        check("rst_c11", 0, int'(d_c[0][0]), 0);
        tick();
        done_cnt = '{0, 0};
        pulse_start(s_cyc);
        repeat (50) tick();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 4; j++) check("post_rst_c", d, int'(d_c[d][j]), 9);
            check("post_rst_done_cnt", d, done_cnt[d], 1);
            check("post_rst_rv", d, int'(d_rv[d]), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
